branch_ctl: RTL and testbench

Branch and jump control unit for the core's fetch path. It is the initiator side of the program counter's jump interface: each cycle it decides whether the program counter takes a jump and supplies the absolute target. It decodes the branch operation, evaluates a registered zero flag, resolves targets through a programmable target lookup table (LUT), and keeps a hardware return-address stack for CALL/RET.

---
 rtl/branch_ctl_if.sv | 33 +++
 rtl/branch_ctl.sv | 119 +++++++++++
 tb/tb_branch_ctl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/branch_ctl_if.sv
// Jump interface between the branch control unit (master) and the program counter
// side (slave), including the return-stack status lines.
interface branch_ctl_if #(
  parameter int D  = 8,
  parameter int LW = 4,
  parameter int SD = 4
);
  localparam int DW = $clog2(SD) + 1;

  logic [2:0]    op;
  logic [LW-1:0] lut_idx;
  logic [D-1:0]  prog_ctr;
  logic          zero_in;
  logic          flag_we;
  logic          lut_we;
  logic [LW-1:0] lut_waddr;
  logic [D-1:0]  lut_wdata;
  logic          jump_en;
  logic [D-1:0]  target;
  logic [DW-1:0] depth;
  logic          stack_ovf;
  logic          stack_unf;

  modport master (
    input  op, lut_idx, prog_ctr, zero_in, flag_we, lut_we, lut_waddr, lut_wdata,
    output jump_en, target, depth, stack_ovf, stack_unf
  );

  modport slave (
    output op, lut_idx, prog_ctr, zero_in, flag_we, lut_we, lut_waddr, lut_wdata,
    input  jump_en, target, depth, stack_ovf, stack_unf
  );
endinterface

// File: rtl/branch_ctl.sv
// Branch/jump control: decodes the branch op against a registered zero flag,
// resolves targets through a writable LUT and keeps a return-address stack.
module branch_ctl #(
  parameter int D  = 8,
  parameter int LW = 4,
  parameter int SD = 4
) (
  input  logic          clk,
  input  logic          reset,
  branch_ctl_if.master  bus
);
  localparam int AW = $clog2(SD);
  localparam int DW = AW + 1;
  localparam int NL = 2 ** LW;

  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BZ   = 3'b010;
  localparam logic [2:0] OP_BNZ  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  logic          flag_q, flag_d;
  logic [D-1:0]  lut_q [NL];
  logic [D-1:0]  lut_d [NL];
  logic [D-1:0]  stk_q [SD];
  logic [D-1:0]  stk_d [SD];
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          jump_en;
  logic [D-1:0]  target;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] top_idx;
  logic [D-1:0]  pc_inc;
  logic          full;
  logic          empty;

  // Stack grows upward: depth is the next free slot, depth-1 is the top.
  assign push_idx = depth_q[AW-1:0];
  assign top_idx  = push_idx - AW'(1);
  assign pc_inc   = bus.prog_ctr + D'(1);
  assign full     = (depth_q == DW'(SD));
  assign empty    = (depth_q == '0);

  always_comb begin
    jump_en = 1'b0;
    target  = '0;
    flag_d  = flag_q;
    lut_d   = lut_q;
    stk_d   = stk_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    if (bus.flag_we) flag_d = bus.zero_in;
    if (bus.lut_we)  lut_d[bus.lut_waddr] = bus.lut_wdata;

    case (bus.op)
      OP_JMP: begin
        jump_en = 1'b1;
        target  = lut_q[bus.lut_idx];
      end
      OP_BZ: begin
        jump_en = flag_q;
        target  = lut_q[bus.lut_idx];
      end
      OP_BNZ: begin
        jump_en = ~flag_q;
        target  = lut_q[bus.lut_idx];
      end
      OP_CALL: begin
        jump_en = 1'b1;
        target  = lut_q[bus.lut_idx];
        // A full stack still takes the jump; only the return address is lost.
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          stk_d[push_idx] = pc_inc;
          depth_d         = depth_q + DW'(1);
        end
      end
      OP_RET: begin
        if (empty) begin
          unf_d = 1'b1;
        end else begin
          jump_en = 1'b1;
          target  = stk_q[top_idx];
          depth_d = depth_q - DW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q  <= 1'b0;
      lut_q   <= '{default: '0};
      stk_q   <= '{default: '0};
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flag_q  <= flag_d;
      lut_q   <= lut_d;
      stk_q   <= stk_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.jump_en   = jump_en;
  assign bus.target    = target;
  assign bus.depth     = depth_q;
  assign bus.stack_ovf = ovf_q;
  assign bus.stack_unf = unf_q;
endmodule

// File: tb/tb_branch_ctl.sv
// Directed bench for branch_ctl: LUT jumps, flag branches, call/return nesting,
// stack overflow/underflow, PC wrap and mid-sequence reset.
module tb_branch_ctl;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  localparam logic [2:0] NOP = 3'b000, JMP = 3'b001, BZ = 3'b010, BNZ = 3'b011,
                         CALL = 3'b100, RET = 3'b101, RSV = 3'b110;

  branch_ctl_if #(.D(8), .LW(4), .SD(4)) bus ();

  branch_ctl #(.D(8), .LW(4), .SD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [3:0] idx, input logic [7:0] pc);
    bus.op       = o;
    bus.lut_idx  = idx;
    bus.prog_ctr = pc;
    #2;
  endtask

  task automatic lut_write(input logic [3:0] a, input logic [7:0] d);
    bus.lut_we    = 1'b1;
    bus.lut_waddr = a;
    bus.lut_wdata = d;
    tick();
    bus.lut_we = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.op        = NOP;
    bus.lut_idx   = '0;
    bus.prog_ctr  = '0;
    bus.zero_in   = 1'b0;
    bus.flag_we   = 1'b0;
    bus.lut_we    = 1'b0;
    bus.lut_waddr = '0;
    bus.lut_wdata = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    drive(NOP, 4'd0, 8'h00);
    chk("rst_depth", bus.depth, 0);
    chk("rst_ovf", bus.stack_ovf, 0);
    chk("rst_unf", bus.stack_unf, 0);
    chk("nop_je", bus.jump_en, 0);
    chk("nop_tgt", bus.target, 0);
    drive(JMP, 4'd3, 8'h00);
    chk("rst_lut_tgt", bus.target, 8'h00);
    drive(BZ, 4'd3, 8'h00);
    chk("rst_flag_bz", bus.jump_en, 0);

    // LUT and jumps
    drive(NOP, 4'd0, 8'h00);
    lut_write(4'd3, 8'h40);
    drive(JMP, 4'd3, 8'h00);
    chk("jmp_je", bus.jump_en, 1);
    chk("jmp_tgt", bus.target, 8'h40);
    bus.lut_we = 1'b1; bus.lut_waddr = 4'd5; bus.lut_wdata = 8'h22;
    drive(JMP, 4'd5, 8'h00);
    chk("lut_same_cycle_old", bus.target, 8'h00);
    tick();
    bus.lut_we = 1'b0;
    drive(JMP, 4'd5, 8'h00);
    chk("lut_next_cycle_new", bus.target, 8'h22);

    // Flag branches
    bus.flag_we = 1'b1; bus.zero_in = 1'b1;
    drive(NOP, 4'd0, 8'h00);
    tick();
    bus.flag_we = 1'b0;
    drive(BZ, 4'd3, 8'h00);
    chk("bz_taken_je", bus.jump_en, 1);
    chk("bz_taken_tgt", bus.target, 8'h40);
    drive(BNZ, 4'd3, 8'h00);
    chk("bnz_not_taken_je", bus.jump_en, 0);
    chk("bnz_not_taken_tgt", bus.target, 8'h40);
    bus.flag_we = 1'b1; bus.zero_in = 1'b0;
    drive(BZ, 4'd3, 8'h00);
    chk("bz_old_flag", bus.jump_en, 1);
    tick();
    bus.flag_we = 1'b0;
    drive(BZ, 4'd3, 8'h00);
    chk("bz_new_flag", bus.jump_en, 0);
    drive(BNZ, 4'd5, 8'h00);
    chk("bnz_taken_je", bus.jump_en, 1);
    chk("bnz_taken_tgt", bus.target, 8'h22);
    drive(RSV, 4'd3, 8'h00);
    chk("rsv_je", bus.jump_en, 0);
    chk("rsv_tgt", bus.target, 8'h00);

    // Call/return nesting
    drive(NOP, 4'd0, 8'h00);
    lut_write(4'd1, 8'h10);
    lut_write(4'd2, 8'h20);
    drive(CALL, 4'd1, 8'h05);
    chk("call1_je", bus.jump_en, 1);
    chk("call1_tgt", bus.target, 8'h10);
    tick();
    chk("call1_depth", bus.depth, 1);
    drive(CALL, 4'd2, 8'h12);
    chk("call2_tgt", bus.target, 8'h20);
    tick();
    chk("call2_depth", bus.depth, 2);
    drive(RET, 4'd0, 8'h20);
    chk("ret1_je", bus.jump_en, 1);
    chk("ret1_tgt", bus.target, 8'h13);
    tick();
    chk("ret1_depth", bus.depth, 1);
    drive(RET, 4'd0, 8'h13);
    chk("ret2_tgt", bus.target, 8'h06);
    tick();
    chk("ret2_depth", bus.depth, 0);

    // Overflow
    for (int i = 1; i <= 5; i++) begin
      drive(CALL, 4'd1, 8'(i));
      chk($sformatf("ovf_call%0d_je", i), bus.jump_en, 1);
      tick();
    end
    chk("ovf_depth", bus.depth, 4);
    chk("ovf_sticky", bus.stack_ovf, 1);
    for (int i = 0; i < 4; i++) begin
      drive(RET, 4'd0, 8'h10);
      chk($sformatf("ovf_ret%0d_tgt", i), bus.target, 32'(5 - i));
      tick();
    end
    chk("ovf_drain_depth", bus.depth, 0);
    chk("ovf_still_set", bus.stack_ovf, 1);

    // Underflow and wrap
    drive(RET, 4'd0, 8'h00);
    chk("unf_je", bus.jump_en, 0);
    chk("unf_tgt", bus.target, 0);
    tick();
    chk("unf_sticky", bus.stack_unf, 1);
    chk("unf_depth", bus.depth, 0);
    drive(CALL, 4'd1, 8'hFF);
    tick();
    drive(RET, 4'd0, 8'h10);
    chk("wrap_je", bus.jump_en, 1);
    chk("wrap_tgt", bus.target, 8'h00);
    tick();

    // Reset mid-operation
    bus.flag_we = 1'b1; bus.zero_in = 1'b1;
    drive(CALL, 4'd1, 8'h30);
    tick();
    bus.flag_we = 1'b0;
    drive(CALL, 4'd1, 8'h31);
    tick();
    drive(CALL, 4'd1, 8'h32);
    tick();
    reset = 1'b1;
    drive(RET, 4'd0, 8'h10);
    chk("rstcyc_depth", bus.depth, 3);
    chk("rstcyc_ret_tgt", bus.target, 8'h33);
    tick();
    reset = 1'b0;
    drive(NOP, 4'd0, 8'h00);
    chk("postrst_depth", bus.depth, 0);
    chk("postrst_ovf", bus.stack_ovf, 0);
    chk("postrst_unf", bus.stack_unf, 0);
    drive(JMP, 4'd3, 8'h00);
    chk("postrst_lut3", bus.target, 8'h00);
    drive(JMP, 4'd1, 8'h00);
    chk("postrst_lut1", bus.target, 8'h00);
    drive(BZ, 4'd1, 8'h00);
    chk("postrst_flag", bus.jump_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
